// File: rtl/conv_pkg.sv
// Shared widths and constants for the 3x3 convolution datapath.
// Derived widths below describe the default 8-bit configuration.
package conv_pkg;

  localparam int DEF_NB_COEFF    = 8;
  localparam int DEF_NB_DATA     = 8;
  localparam int DEF_NB_OUTPUT   = 8;
  localparam int DEF_KERNEL_SIZE = 9;

  localparam int NB_PROD     = DEF_NB_DATA + DEF_NB_COEFF + 1;
  localparam int NB_ACC      = NB_PROD + 4;
  localparam int NB_FRAC     = DEF_NB_COEFF - 1;
  localparam int ROUND_CONST = 1 << (NB_FRAC - 1);
  localparam int CENTER_TAP  = 4;

endpackage

// File: rtl/conv_2d_3x3_round_sat.sv
// Converts the full-precision signed accumulator to an unsigned output pixel.
// Rounds to nearest (ties toward +inf), then clamps to [0, 2^OUT_W-1].
module round_sat
  import conv_pkg::*;
#(
  parameter int ACC_W  = NB_ACC,
  parameter int FRAC_W = NB_FRAC,
  parameter int OUT_W  = DEF_NB_OUTPUT
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] pixel
);

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_VAL = ACC_W'((1 << OUT_W) - 1);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  // The accumulator has four bits of headroom, so adding the rounding constant cannot wrap.
  always_comb begin
    rounded = acc + RND;
    shifted = rounded >>> FRAC_W;
    if (shifted[ACC_W-1]) begin
      pixel = '0;
    end else if (shifted > MAX_VAL) begin
      pixel = '1;
    end else begin
      pixel = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_2d_3x3.sv
// Single-cycle 3x3 convolution: nine signed multipliers, an adder tree,
// round/saturate and one output register (latency 1 clock).
module conv_2d_3x3
  import conv_pkg::*;
#(
  parameter int NB_COEFF    = DEF_NB_COEFF,
  parameter int NB_DATA     = DEF_NB_DATA,
  parameter int NB_OUTPUT   = DEF_NB_OUTPUT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic [NB_COEFF*KERNEL_SIZE-1:0] i_kernel,
  input  logic [NB_DATA*KERNEL_SIZE-1:0]  i_data,
  output logic [NB_OUTPUT-1:0]            o_pixel
);

  localparam int PROD_W = NB_DATA + NB_COEFF + 1;
  localparam int ROW_W  = PROD_W + 2;
  localparam int ACC_W  = PROD_W + 4;
  localparam int FRAC_W = NB_COEFF - 1;

  if (KERNEL_SIZE != 9) begin : g_bad_kernel_size
    $error("conv_2d_3x3 supports only KERNEL_SIZE = 9");
  end

  logic signed [PROD_W-1:0] prod [KERNEL_SIZE];
  logic signed [ROW_W-1:0]  row_sum [3];
  logic signed [ACC_W-1:0]  acc;
  logic        [NB_OUTPUT-1:0] pixel_next;

  // Pixels are unsigned, so a zero bit is prepended before the signed multiply.
  for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_tap
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] coeff_ext;
    assign data_ext  = PROD_W'($signed({1'b0, i_data[k*NB_DATA +: NB_DATA]}));
    assign coeff_ext = PROD_W'($signed(i_kernel[k*NB_COEFF +: NB_COEFF]));
    assign prod[k]   = data_ext * coeff_ext;
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign row_sum[r] = ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
  end

  assign acc = ACC_W'(row_sum[0]) + ACC_W'(row_sum[1]) + ACC_W'(row_sum[2]);

  round_sat #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W),
    .OUT_W  (NB_OUTPUT)
  ) u_round_sat (
    .acc   (acc),
    .pixel (pixel_next)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel <= '0;
    end else begin
      o_pixel <= pixel_next;
    end
  end

endmodule

// File: tb/tb_conv_2d_3x3.sv
// Scoreboard bench for conv_2d_3x3: inputs change on the falling edge and
// expectations are popped one falling edge later, after the capturing rising edge.
module tb_conv_2d_3x3;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [71:0] i_kernel;
  logic [71:0] i_data;
  logic [7:0]  o_pixel;

  int exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_2d_3x3 dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_kernel (i_kernel),
    .i_data   (i_data),
    .o_pixel  (o_pixel)
  );

  function automatic logic [71:0] splat(input logic [7:0] v);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [71:0] with_centre(input logic [7:0] centre, input logic [7:0] rest);
    logic [71:0] r;
    r = splat(rest);
    r[4*8 +: 8] = centre;
    return r;
  endfunction

  // Reference: integer sum of products, floor((s + 64) / 128), clamp to 0..255.
  function automatic int model(input logic [71:0] d, input logic [71:0] kr);
    int s;
    logic [7:0] px;
    logic signed [7:0] cf;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      px = d[k*8 +: 8];
      cf = kr[k*8 +: 8];
      s += int'(px) * int'(cf);
    end
    s = s + 64;
    s = (s >= 0) ? (s / 128) : -((-s + 127) / 128);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic apply_stimulus(input logic [71:0] d, input logic [71:0] kr, input int e);
    i_data   = d;
    i_kernel = kr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int e;
    i_rst    = 1'b1;
    i_data   = with_centre(8'd5, 8'd0);
    i_kernel = with_centre(8'h7F, 8'h00);
    #1;
    n_cmp++;
    if (o_pixel !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_initial: o_pixel=%0d expected 0", o_pixel);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_pixel !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_held_edge: o_pixel=%0d expected 0", o_pixel);
    end
    @(negedge clk);
    i_rst = 1'b0;
    apply_stimulus(i_data, i_kernel, 5);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_pixel !== 8'(e)) begin
      n_fail++;
      $display("[TB] FAIL reset_first_edge: o_pixel=%0d expected %0d", o_pixel, e);
    end
  endtask

  task automatic test_reset_mid_stream();
    int e;
    apply_stimulus(with_centre(8'd9, 8'd1), with_centre(8'h7F, 8'h00), 9);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_pixel !== 8'(e)) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: o_pixel=%0d expected %0d", o_pixel, e);
    end
    #2 i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_pixel !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: o_pixel=%0d expected 0", o_pixel);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_pixel !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: o_pixel=%0d expected 0", o_pixel);
    end
    @(negedge clk);
    #1 i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_pixel !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_release_pre_edge: o_pixel=%0d expected 0", o_pixel);
    end
    exp_q.push_back(9);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_pixel !== 8'(e)) begin
      n_fail++;
      $display("[TB] FAIL reset_resume: o_pixel=%0d expected %0d", o_pixel, e);
    end
  endtask

  task automatic test_identity();
    int e;
    logic [71:0] d;
    for (int c = 1; c <= 7; c++) begin
      d = '0;
      for (int k = 0; k < 9; k++) d[k*8 +: 8] = 8'($urandom_range(1, 0));
      d[4*8 +: 8] = 8'(c);
      apply_stimulus(d, with_centre(8'h7F, 8'h00), c);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_pixel !== 8'(e)) begin
        n_fail++;
        $display("[TB] FAIL identity_c%0d: o_pixel=%0d expected %0d", c, o_pixel, e);
      end
    end
  endtask

  task automatic test_boundaries();
    int e;
    string names[7] = '{"box", "sat_high", "sat_low_centre", "sat_low_all",
                        "zero_kernel", "round_3", "round_1"};
    apply_stimulus(splat(8'd8),   splat(8'h10), 9);
    apply_stimulus(splat(8'd255), splat(8'h7F), 255);
    apply_stimulus(with_centre(8'd200, 8'd0), with_centre(8'h80, 8'h00), 0);
    apply_stimulus(splat(8'd255), splat(8'h80), 0);
    apply_stimulus(splat(8'd255), splat(8'h00), 0);
    apply_stimulus(with_centre(8'd3, 8'd0), with_centre(8'h40, 8'h00), 2);
    apply_stimulus(with_centre(8'd1, 8'd0), with_centre(8'h40, 8'h00), 1);
    // All seven expectations are queued; replay the vectors one per cycle.
    exp_q.delete();
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: apply_stimulus(splat(8'd8),   splat(8'h10), 9);
        1: apply_stimulus(splat(8'd255), splat(8'h7F), 255);
        2: apply_stimulus(with_centre(8'd200, 8'd0), with_centre(8'h80, 8'h00), 0);
        3: apply_stimulus(splat(8'd255), splat(8'h80), 0);
        4: apply_stimulus(splat(8'd255), splat(8'h00), 0);
        5: apply_stimulus(with_centre(8'd3, 8'd0), with_centre(8'h40, 8'h00), 2);
        default: apply_stimulus(with_centre(8'd1, 8'd0), with_centre(8'h40, 8'h00), 1);
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_pixel !== 8'(e)) begin
        n_fail++;
        $display("[TB] FAIL %s: o_pixel=%0d expected %0d", names[t], o_pixel, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [71:0] d;
    logic [71:0] kr;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 9; k++) begin
        d[k*8 +: 8]  = 8'($urandom);
        kr[k*8 +: 8] = (i % 3 == 0) ? 8'($urandom_range(32, 0)) : 8'($urandom);
      end
      apply_stimulus(d, kr, model(d, kr));
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL scoreboard_empty: cycle %0d had no expectation", i);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (o_pixel !== 8'(e)) begin
          n_fail++;
          $display("[TB] FAIL random_%0d: o_pixel=%0d expected %0d", i, o_pixel, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reset_mid_stream();
    test_boundaries();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
